// File: rtl/requant_relu_2_pkg.sv
// Shared parameters for the network datapath plus the local types of the
// requant_relu_2 stage.
//   nn_parameters      : layer sizes and widths common to the dense layers.
//   requant_relu_2_pkg : defaults for requant_relu_2 and its FSM state type.
package nn_parameters;
    localparam int OUT_SIZE_2  = 32'd64;  // elements produced by dense_layer_2
    localparam int ACC_W_2     = 32'd24;  // dense_layer_2 accumulator width
    localparam int DATA_W      = 32'd16;  // activation width between layers
    localparam int REQ_SHIFT_2 = 32'd8;   // requant shift after dense_layer_2
endpackage

package requant_relu_2_pkg;
    localparam int DEF_VEC_SIZE = nn_parameters::OUT_SIZE_2;
    localparam int DEF_IN_W     = nn_parameters::ACC_W_2;
    localparam int DEF_OUT_W    = nn_parameters::DATA_W;
    localparam int DEF_SHIFT    = nn_parameters::REQ_SHIFT_2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/requant_relu_2_if.sv
// Handshake and data bundle between the layer sequencer and requant_relu_2.
//   start         : one-cycle request (sequencer -> stage)
//   input_vector  : accumulator vector from dense_layer_2 (sequencer -> stage)
//   output_vector : requantised signed vector (stage -> sequencer)
//   busy, done    : run status and one-cycle completion pulse (stage -> sequencer)
interface requant_relu_2_if
    import requant_relu_2_pkg::*;
#(
    parameter int VEC_SIZE = DEF_VEC_SIZE,
    parameter int IN_W     = DEF_IN_W,
    parameter int OUT_W    = DEF_OUT_W
);
    logic                    start;
    logic        [IN_W-1:0]  input_vector  [VEC_SIZE];
    logic signed [OUT_W-1:0] output_vector [VEC_SIZE];
    logic                    busy;
    logic                    done;

    modport master (
        output start,
        output input_vector,
        input  output_vector,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  input_vector,
        output output_vector,
        output busy,
        output done
    );
endinterface

// File: rtl/requant_relu_unit.sv
// Combinational requantisation of one accumulator element:
// ReLU, round-half-up arithmetic right shift by SHIFT, saturate to signed OUT_W.
//   in  : signed IN_W accumulator value
//   out : signed OUT_W result (never negative)
module requant_relu_unit #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8
) (
    input  logic signed [IN_W-1:0]  in,
    output logic signed [OUT_W-1:0] out
);
    // Rounding term 2^(SHIFT-1) and largest positive OUT_W value, both at IN_W+1 bits.
    localparam logic [IN_W:0] ROUND   = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [IN_W:0] MAX_POS = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};

    logic [IN_W:0] sum_s;
    logic [IN_W:0] r_s;

    // ReLU, rounded shift and saturation; one extra bit keeps the rounding add from overflowing.
    always_comb begin
        sum_s = {in[IN_W-1], in} + ROUND;
        // Only non-negative inputs reach the output, so a logical shift equals the arithmetic one.
        r_s   = sum_s >> SHIFT;
        if (in[IN_W-1]) begin
            out = {OUT_W{1'b0}};
        end else if (r_s > MAX_POS) begin
            out = {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            out = r_s[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/requant_relu_2.sv
// Sequential requantisation stage after dense_layer_2. On start it snapshots
// the accumulator vector, then converts one element per clock through a single
// requant_relu_unit and writes it into the registered output vector.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : requant_relu_2_if slave (start, input_vector, output_vector, busy, done)
// Timing: start sampled at edge E0 -> busy high after E0, element i written at
// edge E0+1+i, done high for one cycle after edge E0+VEC_SIZE+1.
module requant_relu_2
    import requant_relu_2_pkg::*;
#(
    parameter int VEC_SIZE = DEF_VEC_SIZE,
    parameter int IN_W     = DEF_IN_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int SHIFT    = DEF_SHIFT
) (
    input  logic            clk,
    input  logic            rst,
    requant_relu_2_if.slave bus
);
    localparam int               IDX_W    = $clog2(VEC_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_SIZE - 1);

    state_e                  state_r;
    state_e                  state_s;
    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_s;
    logic                    accept_s;
    logic                    busy_s;
    logic                    done_s;
    logic                    busy_r;
    logic                    done_r;
    logic        [IN_W-1:0]  snap_r [VEC_SIZE];
    logic signed [OUT_W-1:0] out_r  [VEC_SIZE];
    logic signed [OUT_W-1:0] f_s;

    requant_relu_unit #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_unit (
        .in  (snap_r[idx_r]),
        .out (f_s)
    );

    // Next-state, index and registered-output values of the control FSM.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // done_r high means the completion cycle is still in progress.
                if (bus.start && !done_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_PROC;
                    idx_s    = {IDX_W{1'b0}};
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_PROC: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    idx_s = idx_r + IDX_W'(1'b1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                idx_s   = {IDX_W{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = {IDX_W{1'b0}};
            end
        endcase
        // busy covers the run plus the done cycle that follows the DONE state.
        busy_s = (state_s != ST_IDLE) || (state_r == ST_DONE);
        done_s = (state_r == ST_DONE);
    end

    // Control state, element index and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Snapshot of the input vector, captured only when a run is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VEC_SIZE; i++) begin
                snap_r[i] <= {IN_W{1'b0}};
            end
        end else if (accept_s) begin
            snap_r <= bus.input_vector;
        end else begin
            snap_r <= snap_r;
        end
    end

    // Output vector: one element rewritten per PROC cycle, all others hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VEC_SIZE; i++) begin
                out_r[i] <= {OUT_W{1'b0}};
            end
        end else if (state_r == ST_PROC) begin
            out_r[idx_r] <= f_s;
        end else begin
            out_r <= out_r;
        end
    end

    assign bus.output_vector = out_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
endmodule

// File: tb/tb_requant_relu_2.sv
// Directed testbench for requant_relu_2: reset, arithmetic corners, exact
// start-to-done timing, input decoupling, ignored starts, mid-run reset and
// back-to-back runs. Inputs change and outputs are sampled 1 ns after posedge.
module tb_requant_relu_2;
    localparam int VEC = 64;

    logic clk;
    logic rst;
    int   total;
    int   passes;
    int   n;
    int   bad;

    requant_relu_2_if bus ();

    requant_relu_2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ticks until done is seen high; n ends as the number of edges after the start edge.
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    function automatic int count_nonzero();
        int c = 0;
        for (int i = 0; i < VEC; i++) begin
            if (bus.output_vector[i] !== 16'sd0) c++;
        end
        return c;
    endfunction

    function automatic int count_not_index();
        int c = 0;
        for (int i = 0; i < VEC; i++) begin
            if (bus.output_vector[i] !== 16'(i)) c++;
        end
        return c;
    endfunction

    initial begin
        total  = 0;
        passes = 0;
        rst    = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < VEC; i++) bus.input_vector[i] = 24'(i * 256);

        // Reset held for 3 cycles with start asserted.
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_outputs_zero", 32'(count_nonzero()), 32'd0);
        rst = 1'b0;
        bus.start = 1'b0;
        tick();
        check("rst_no_run", 32'(bus.busy), 32'd0);

        // Timing run with input[i]=i*256; inputs change and start pulses mid-run.
        bus.start = 1'b1;
        tick();                                   // E0
        bus.start = 1'b0;
        check("run1_busy_rise", 32'(bus.busy), 32'd1);
        check("run1_done_low", 32'(bus.done), 32'd0);
        for (int i = 0; i < VEC; i++) bus.input_vector[i] = 24'h7FFFFF;
        repeat (9) tick();                        // E0+9
        bus.start = 1'b1;
        tick();                                   // E0+10, ignored
        bus.start = 1'b0;
        repeat (54) tick();                       // E0+64
        check("run1_done_not_early", 32'(bus.done), 32'd0);
        check("run1_busy_e64", 32'(bus.busy), 32'd1);
        tick();                                   // E0+65
        check("run1_done_high", 32'(bus.done), 32'd1);
        check("run1_busy_with_done", 32'(bus.busy), 32'd1);
        tick();                                   // E0+66
        check("run1_done_one_cycle", 32'(bus.done), 32'd0);
        check("run1_busy_fall", 32'(bus.busy), 32'd0);
        check("run1_out_eq_index", 32'(count_not_index()), 32'd0);
        check("run1_out63", 32'(bus.output_vector[63]), 32'd63);
        repeat (5) tick();
        check("run1_no_second_run", 32'(bus.busy), 32'd0);

        // Arithmetic corners with SHIFT=8; remaining elements are zero.
        for (int i = 0; i < VEC; i++) bus.input_vector[i] = 24'h000000;
        bus.input_vector[0] = 24'h000180;
        bus.input_vector[1] = 24'h00007F;
        bus.input_vector[2] = 24'h000080;
        bus.input_vector[3] = 24'h7FFFFF;
        bus.input_vector[4] = 24'hFFFF00;
        bus.start = 1'b1;
        tick();                                   // E0
        bus.start = 1'b0;
        repeat (32) tick();                       // elements 0..31 rewritten
        check("hold_out63_old", 32'(bus.output_vector[63]), 32'd63);
        check("hold_out0_new", 32'(bus.output_vector[0]), 32'd2);
        wait_done(n);
        check("corner_done_latency", 32'(n + 32), 32'd65);
        check("corner_0x000180", 32'(bus.output_vector[0]), 32'd2);
        check("corner_0x00007F", 32'(bus.output_vector[1]), 32'd0);
        check("corner_0x000080", 32'(bus.output_vector[2]), 32'd1);
        check("corner_0x7FFFFF_sat", 32'(bus.output_vector[3]), 32'd32767);
        check("corner_0xFFFF00_neg", 32'(bus.output_vector[4]), 32'd0);
        check("corner_out63_zero", 32'(bus.output_vector[63]), 32'd0);
        repeat (3) tick();

        // Reset asserted at E0+30 for one cycle.
        for (int i = 0; i < VEC; i++) bus.input_vector[i] = 24'(i * 256);
        bus.start = 1'b1;
        tick();                                   // E0
        bus.start = 1'b0;
        repeat (29) tick();                       // E0+29
        check("midrst_pre_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();                                   // E0+30
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_outputs_zero", 32'(count_nonzero()), 32'd0);
        bad = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) bad++;
        end
        check("midrst_no_done", 32'(bad), 32'd0);

        // Run after reset, then back-to-back starts around the done pulse.
        bus.start = 1'b1;
        tick();                                   // E1
        bus.start = 1'b0;
        wait_done(n);
        check("b2b_first_latency", 32'(n), 32'd65);
        bus.start = 1'b1;                         // sampled while done is high
        tick();                                   // E1+66
        check("b2b_start_during_done_ignored", 32'(bus.busy), 32'd0);
        check("b2b_done_fell", 32'(bus.done), 32'd0);
        tick();                                   // E2 = E1+67, accepted
        bus.start = 1'b0;
        check("b2b_second_accepted", 32'(bus.busy), 32'd1);
        wait_done(n);
        check("b2b_second_latency", 32'(n), 32'd65);
        check("b2b_out_eq_index", 32'(count_not_index()), 32'd0);
        repeat (4) tick();
        check("b2b_idle_after", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
